rst_scoreboard: RTL and testbench
=================================

# rst_scoreboard

Parametrised register status table (RST) for the dispatch stage. It tracks, per architectural register, whether a result is pending, which functional unit (tag) will produce it, and whether the producer was issued under an unresolved branch. It serves N operand lookups per cycle and accepts M writeback clears per cycle. On branch resolution it either commits or squashes speculative entries. It replaces the fixed 32-entry scalar and 16-entry matrix RST rows with one block instantiated twice.

## Interface
Parameters:
- NREGS, 32: number of tracked registers; a power of two, at least 2.
- TAG_W, 2: width of the FU tag.
- NRD, 2: number of operand lookup ports.
- NWB, 2: number of writeback clear ports.
- ZERO_REG, 1: when 1, register 0 is never marked busy (scalar instance); 0 for the matrix instance.

Ports (RIDX_W = log2(NREGS)):
- CLK  in  1  clock. One clock domain.
- nRST  in  1  reset. Asynchronous, active-low.
- disp_en  in  1  dispatch requests allocation of disp_rd.
- disp_rd  in  RIDX_W  destination register.
- disp_tag  in  TAG_W  producing FU tag.
- disp_spec  in  1  producer is issued under an unresolved branch.
- disp_ready  out  1  combinational; the allocation is accepted this cycle.
- rd_idx  in  NRD×RIDX_W  operand registers to look up.
- rd_busy  out  NRD  combinational; busy bit of each looked-up row.
- rd_tag  out  NRD×TAG_W  combinational; tag of each looked-up row.
- wb_en  in  NWB  writeback valid.
- wb_rd  in  NWB×RIDX_W  written register.
- wb_tag  in  NWB×TAG_W  tag of the writing FU.
- br_resolved  in  1  branch resolved as correctly predicted.
- br_miss  in  1  branch mispredicted.
- busy_vec  out  NREGS  registered busy bits.
- spec_count  out  RIDX_W+1  registered count of rows with spec=1.
- wb_err  out  1  sticky; a writeback did not match any busy row.

## Operation
- Each row holds {busy, tag, spec}. All rows reset to 0.
- Lookup:
  - rd_busy/rd_tag come from registered state, with a same-cycle bypass: if a matching writeback clears the row this cycle, rd_busy=0.
  - No bypass from a same-cycle dispatch.
- Writeback, port k, when wb_en[k]:
  - If row wb_rd[k] is busy and its tag equals wb_tag[k], clear busy and spec. Decrement spec_count if spec was 1.
  - Otherwise set wb_err. wb_err clears only on reset.
  - Several ports hitting the same row in one cycle clear it once; the count is adjusted once.
- Dispatch:
  - disp_ready = !br_miss && !(busy[disp_rd] after writeback bypass).
  - This is a WAW stall: each register has at most one outstanding producer.
  - With ZERO_REG=1 and disp_rd=0: disp_ready=1 and no row changes.
  - When disp_en && disp_ready: row ← {1, disp_tag, disp_spec}. Increment spec_count if disp_spec=1.
- Branch resolution:
  - br_resolved: spec cleared on every row, including a same-cycle dispatch. spec_count ← 0.
  - br_miss: every row with spec=1 gets busy=0 and spec=0; any dispatch in that cycle is rejected. spec_count ← 0.
  - br_resolved and br_miss together: br_miss wins.
- Same-cycle priority per row, highest first: br_miss squash; dispatch write; writeback clear; br_resolved spec clear.
  - A writeback clear and a dispatch to the same row in one cycle leave the new allocation.
- spec_count arithmetic:
  - Next value = current + dispatched_spec − cleared_spec.
  - It cannot exceed NREGS, so the width RIDX_W+1 never wraps.

## Timing
- Row state, busy_vec and spec_count update on the CLK rising edge after the event.
- Lookup and disp_ready are combinational, at zero cycles.
- A register written back in cycle t reads not-busy in cycle t through the bypass.
- A register dispatched in cycle t reads busy from cycle t+1.
- A reset asserted mid-operation clears every row, spec_count and wb_err asynchronously. Outputs read 0 while nRST=0.

## Configuration
- RST_SPEC_EN defined: speculation tracking as described above.
- RST_SPEC_EN undefined:
  - spec storage is removed.
  - disp_spec, br_resolved and br_miss are ignored.
  - disp_ready omits the br_miss term.
  - spec_count is tied to 0.

## Structure
- Shared package datapath_pkg holds:
  - the parametric row layout as a packed struct rst_row_t {tag [1:0], busy, spec}, matching the existing TAG_W default;
  - the constants RST_S_NREGS=32 and RST_M_NREGS=16.
- One natural sub-module: rst_lookup_port. It is a single read mux plus writeback-bypass compare, instantiated NRD times.

## Test plan
- Reset, then lookup of registers 5 and 7 → rd_busy=00, busy_vec=0, spec_count=0, wb_err=0.
- Dispatch rd=5, tag=2; next cycle lookup 5 → busy=1, tag=2. Dispatch rd=5 again → disp_ready=0. wb rd=5, tag=2 with a same-cycle dispatch rd=5, tag=1 → accepted; row 5 = busy with tag=1.
- ZERO_REG=1: dispatch rd=0 → disp_ready=1 and busy_vec[0] stays 0.
- Spec dispatch of rd=3 and rd=4, plus non-spec rd=6 → spec_count=2. br_miss → rows 3 and 4 clear, row 6 stays busy, spec_count=0.
- Spec dispatch rd=9; br_resolved in the same cycle as a spec dispatch of rd=10 → both rows busy with spec=0, spec_count=0. A following br_miss leaves both busy.
- wb rd=12, tag=1 to an idle row → wb_err=1. It stays 1 through later traffic and clears only on nRST.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared dispatch-stage datapath types and register status table sizing.
// Row layout matches the default two-bit functional-unit tag.
package datapath_pkg;

    typedef struct packed {
        logic [1:0] tag;
        logic       busy;
        logic       spec;
    } rst_row_t;

    localparam int RST_S_NREGS = 32;
    localparam int RST_M_NREGS = 16;

endpackage

// File: rtl/rst_lookup_port.sv
// One operand lookup: read mux over the status rows plus the writeback bypass compare.
// Latency: combinational. Backpressure: none; the port always answers.
// Configuration: no build options.
module rst_lookup_port #(
    parameter int NREGS  = 32,
    parameter int TAG_W  = 2,
    parameter int NWB    = 2,
    parameter int RIDX_W = 5
) (
    input  logic [RIDX_W-1:0]           i_idx,
    input  logic [NREGS-1:0]            i_busy,
    input  logic [NREGS-1:0][TAG_W-1:0] i_tag,
    input  logic [NWB-1:0]              i_wb_en,
    input  logic [NWB*RIDX_W-1:0]       i_wb_rd,
    input  logic [NWB*TAG_W-1:0]        i_wb_tag,
    output logic                        o_busy,
    output logic [TAG_W-1:0]            o_tag
);

    logic [TAG_W-1:0] w_tag;
    logic             w_hit;

    assign w_tag = i_tag[i_idx];

    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < NWB; k++) begin
            if (i_wb_en[k] && (i_wb_rd[k*RIDX_W +: RIDX_W] == i_idx) &&
                (i_wb_tag[k*TAG_W +: TAG_W] == w_tag))
                w_hit = 1'b1;
        end
    end

    assign o_busy = i_busy[i_idx] & ~w_hit;
    assign o_tag  = w_tag;

endmodule

// File: rtl/rst_scoreboard.sv
// Register status table: per-register busy/tag/spec with N lookups, M writeback clears, branch commit/squash.
// Latency: lookups and disp_ready combinational; row state updates on the next CLK edge.
// Backpressure: disp_ready drops on a WAW hazard (or a mispredict); speculation tracking only when RST_SPEC_EN is defined.
module rst_scoreboard
    import datapath_pkg::*;
#(
    parameter int NREGS    = RST_S_NREGS,
    parameter int TAG_W    = 2,
    parameter int NRD      = 2,
    parameter int NWB      = 2,
    parameter int ZERO_REG = 1,
    localparam int RIDX_W  = $clog2(NREGS)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    disp_en,
    input  logic [RIDX_W-1:0]       disp_rd,
    input  logic [TAG_W-1:0]        disp_tag,
    input  logic                    disp_spec,
    output logic                    disp_ready,
    input  logic [NRD*RIDX_W-1:0]   rd_idx,
    output logic [NRD-1:0]          rd_busy,
    output logic [NRD*TAG_W-1:0]    rd_tag,
    input  logic [NWB-1:0]          wb_en,
    input  logic [NWB*RIDX_W-1:0]   wb_rd,
    input  logic [NWB*TAG_W-1:0]    wb_tag,
    input  logic                    br_resolved,
    input  logic                    br_miss,
    output logic [NREGS-1:0]        busy_vec,
    output logic [RIDX_W:0]         spec_count,
    output logic                    wb_err
);

    localparam int CNT_W = RIDX_W + 1;

    logic [NREGS-1:0]            r_busy;
    logic [NREGS-1:0][TAG_W-1:0] r_tag;
    logic                        r_wb_err;
    logic [NREGS-1:0]            w_wb_clr;
    logic                        w_wb_miss;
    logic                        w_zero_dst;
    logic                        w_disp_busy;
    logic                        w_disp_we;
    logic [NREGS-1:0]            w_busy_nxt;
    logic [NREGS-1:0][TAG_W-1:0] w_tag_nxt;

    // Matches are judged against registered state, so two ports hitting one row both count as hits.
    always_comb begin
        w_wb_clr  = '0;
        w_wb_miss = 1'b0;
        for (int k = 0; k < NWB; k++) begin
            if (wb_en[k]) begin
                if (r_busy[wb_rd[k*RIDX_W +: RIDX_W]] &&
                    (r_tag[wb_rd[k*RIDX_W +: RIDX_W]] == wb_tag[k*TAG_W +: TAG_W]))
                    w_wb_clr[wb_rd[k*RIDX_W +: RIDX_W]] = 1'b1;
                else
                    w_wb_miss = 1'b1;
            end
        end
    end

    assign w_zero_dst  = (ZERO_REG != 0) && (disp_rd == '0);
    assign w_disp_busy = r_busy[disp_rd] & ~w_wb_clr[disp_rd];
`ifdef RST_SPEC_EN
    assign disp_ready  = nRST & ~br_miss & ~w_disp_busy;
`else
    assign disp_ready  = nRST & ~w_disp_busy;
`endif
    assign w_disp_we   = disp_en & disp_ready & ~w_zero_dst;

`ifdef RST_SPEC_EN
    logic [NREGS-1:0] r_spec;
    logic [NREGS-1:0] w_spec_nxt;
    logic [CNT_W-1:0] r_spec_count;
    logic [CNT_W-1:0] w_spec_clr_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
`endif

    // Later assignments override earlier ones: squash > dispatch > writeback > resolve.
    always_comb begin
        w_busy_nxt = r_busy & ~w_wb_clr;
        w_tag_nxt  = r_tag;
`ifdef RST_SPEC_EN
        w_spec_nxt = br_resolved ? '0 : (r_spec & ~w_wb_clr);
`endif
        if (w_disp_we) begin
            w_busy_nxt[disp_rd] = 1'b1;
            w_tag_nxt[disp_rd]  = disp_tag;
`ifdef RST_SPEC_EN
            w_spec_nxt[disp_rd] = disp_spec & ~br_resolved;
`endif
        end
`ifdef RST_SPEC_EN
        if (br_miss) begin
            w_busy_nxt = w_busy_nxt & ~r_spec;
            w_spec_nxt = '0;
        end
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_busy   <= '0;
            r_tag    <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_tag    <= w_tag_nxt;
            r_wb_err <= r_wb_err | w_wb_miss;
        end
    end

`ifdef RST_SPEC_EN
    always_comb begin
        w_spec_clr_cnt = '0;
        for (int r = 0; r < NREGS; r++)
            w_spec_clr_cnt = w_spec_clr_cnt + CNT_W'(w_wb_clr[r] & r_spec[r]);
        w_cnt_nxt = r_spec_count + CNT_W'(w_disp_we & disp_spec) - w_spec_clr_cnt;
        if (br_miss || br_resolved)
            w_cnt_nxt = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_spec       <= '0;
            r_spec_count <= '0;
        end else begin
            r_spec       <= w_spec_nxt;
            r_spec_count <= w_cnt_nxt;
        end
    end

    assign spec_count = r_spec_count;
`else
    logic w_unused_spec;
    assign w_unused_spec = &{1'b0, disp_spec, br_resolved, br_miss};
    assign spec_count    = '0;
`endif

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        rst_lookup_port #(
            .NREGS  (NREGS),
            .TAG_W  (TAG_W),
            .NWB    (NWB),
            .RIDX_W (RIDX_W)
        ) u_port (
            .i_idx    (rd_idx[g*RIDX_W +: RIDX_W]),
            .i_busy   (r_busy),
            .i_tag    (r_tag),
            .i_wb_en  (wb_en),
            .i_wb_rd  (wb_rd),
            .i_wb_tag (wb_tag),
            .o_busy   (rd_busy[g]),
            .o_tag    (rd_tag[g*TAG_W +: TAG_W])
        );
    end

    assign busy_vec = r_busy;
    assign wb_err   = r_wb_err;

endmodule

// File: tb/tb_rst_scoreboard.sv
// Bench for rst_scoreboard: directed scenarios then random traffic against an array-based reference model.
// Works with or without RST_SPEC_EN; the model follows the same build option.
module tb_rst_scoreboard;

    localparam int NREGS    = 32;
    localparam int TAG_W    = 2;
    localparam int NRD      = 2;
    localparam int NWB      = 2;
    localparam int ZERO_REG = 1;
    localparam int RIDX_W   = $clog2(NREGS);
`ifdef RST_SPEC_EN
    localparam bit SPEC = 1'b1;
`else
    localparam bit SPEC = 1'b0;
`endif

    logic                  CLK;
    logic                  nRST;
    logic                  disp_en;
    logic [RIDX_W-1:0]     disp_rd;
    logic [TAG_W-1:0]      disp_tag;
    logic                  disp_spec;
    logic                  disp_ready;
    logic [NRD*RIDX_W-1:0] rd_idx;
    logic [NRD-1:0]        rd_busy;
    logic [NRD*TAG_W-1:0]  rd_tag;
    logic [NWB-1:0]        wb_en;
    logic [NWB*RIDX_W-1:0] wb_rd;
    logic [NWB*TAG_W-1:0]  wb_tag;
    logic                  br_resolved;
    logic                  br_miss;
    logic [NREGS-1:0]      busy_vec;
    logic [RIDX_W:0]       spec_count;
    logic                  wb_err;

    int checks = 0;
    int errors = 0;

    bit             m_busy[NREGS];
    logic [TAG_W-1:0] m_tag[NREGS];
    bit             m_spec[NREGS];
    bit             m_err;

    rst_scoreboard #(
        .NREGS(NREGS), .TAG_W(TAG_W), .NRD(NRD), .NWB(NWB), .ZERO_REG(ZERO_REG)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .disp_en(disp_en), .disp_rd(disp_rd), .disp_tag(disp_tag), .disp_spec(disp_spec),
        .disp_ready(disp_ready),
        .rd_idx(rd_idx), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_tag(wb_tag),
        .br_resolved(br_resolved), .br_miss(br_miss),
        .busy_vec(busy_vec), .spec_count(spec_count), .wb_err(wb_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        disp_en     = 1'b0;
        disp_rd     = '0;
        disp_tag    = '0;
        disp_spec   = 1'b0;
        wb_en       = '0;
        wb_rd       = '0;
        wb_tag      = '0;
        br_resolved = 1'b0;
        br_miss     = 1'b0;
    endtask

    task automatic set_lookup(input int a, input int b);
        rd_idx[0 +: RIDX_W]      = RIDX_W'(a);
        rd_idx[RIDX_W +: RIDX_W] = RIDX_W'(b);
    endtask

    task automatic set_disp(input int rd, input int tag, input int sp);
        disp_en   = 1'b1;
        disp_rd   = RIDX_W'(rd);
        disp_tag  = TAG_W'(tag);
        disp_spec = sp[0];
    endtask

    task automatic set_wb(input int k, input int rd, input int tag);
        wb_en[k]                  = 1'b1;
        wb_rd[k*RIDX_W +: RIDX_W] = RIDX_W'(rd);
        wb_tag[k*TAG_W +: TAG_W]  = TAG_W'(tag);
    endtask

    function automatic bit wb_clears(input int r);
        bit hit = 1'b0;
        for (int k = 0; k < NWB; k++)
            if (wb_en[k] && int'(wb_rd[k*RIDX_W +: RIDX_W]) == r && m_busy[r] &&
                m_tag[r] == wb_tag[k*TAG_W +: TAG_W])
                hit = 1'b1;
        return hit;
    endfunction

    function automatic int spec_pop();
        int c = 0;
        for (int r = 0; r < NREGS; r++)
            if (m_spec[r]) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
            m_spec[r] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Checks everything against the model at the current (settled) time, then clocks and advances the model.
    task automatic step();
        bit               nb[NREGS];
        logic [TAG_W-1:0] nt[NREGS];
        bit               ns[NREGS];
        logic [NREGS-1:0] bv;
        bit               rdy;
        bit               acc;
        int               dr;
        for (int i = 0; i < NRD; i++) begin
            int l = int'(rd_idx[i*RIDX_W +: RIDX_W]);
            bit eb = m_busy[l] && !wb_clears(l);
            chk("rd_busy", 64'(rd_busy[i]), 64'(eb));
            if (eb) chk("rd_tag", 64'(rd_tag[i*TAG_W +: TAG_W]), 64'(m_tag[l]));
        end
        dr  = int'(disp_rd);
        rdy = !(SPEC && br_miss) && !(m_busy[dr] && !wb_clears(dr));
        chk("disp_ready", 64'(disp_ready), 64'(rdy));
        for (int r = 0; r < NREGS; r++) bv[r] = m_busy[r];
        chk("busy_vec", 64'(busy_vec), 64'(bv));
        chk("spec_count", 64'(spec_count), 64'(spec_pop()));
        chk("wb_err", 64'(wb_err), 64'(m_err));

        nb = m_busy; nt = m_tag; ns = m_spec;
        for (int k = 0; k < NWB; k++) begin
            if (wb_en[k]) begin
                int r = int'(wb_rd[k*RIDX_W +: RIDX_W]);
                if (m_busy[r] && m_tag[r] == wb_tag[k*TAG_W +: TAG_W]) begin
                    nb[r] = 1'b0;
                    ns[r] = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (SPEC && br_resolved)
            for (int r = 0; r < NREGS; r++) ns[r] = 1'b0;
        acc = disp_en && rdy && !(ZERO_REG != 0 && dr == 0);
        if (acc) begin
            nb[dr] = 1'b1;
            nt[dr] = disp_tag;
            ns[dr] = SPEC && disp_spec && !br_resolved;
        end
        if (SPEC && br_miss)
            for (int r = 0; r < NREGS; r++) begin
                if (m_spec[r]) nb[r] = 1'b0;
                ns[r] = 1'b0;
            end
        @(posedge CLK);
        #1;
        m_busy = nb; m_tag = nt; m_spec = ns;
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        #1;
        chk("rst_busy_vec", 64'(busy_vec), 64'(0));
        chk("rst_rd_busy", 64'(rd_busy), 64'(0));
        chk("rst_spec_count", 64'(spec_count), 64'(0));
        chk("rst_wb_err", 64'(wb_err), 64'(0));
        chk("rst_disp_ready", 64'(disp_ready), 64'(0));
        model_clear();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b1;
        idle();
        set_lookup(5, 7);
        #1;
        do_reset();

        // Lookup after reset
        idle(); set_lookup(5, 7); #3;
        chk("reset_lookup", 64'(rd_busy), 64'(0));
        step();

        // Dispatch, WAW stall, writeback bypass with same-cycle reallocation
        idle(); set_disp(5, 2, 0); #3;
        chk("disp5_ready", 64'(disp_ready), 64'(1));
        step();
        idle(); set_lookup(5, 7); set_disp(5, 1, 0); #3;
        chk("lookup5_busy", 64'(rd_busy[0]), 64'(1));
        chk("lookup5_tag", 64'(rd_tag[1:0]), 64'(2));
        chk("waw_stall", 64'(disp_ready), 64'(0));
        step();
        idle(); set_lookup(5, 7); set_wb(0, 5, 2); set_disp(5, 1, 0); #3;
        chk("wb_bypass_ready", 64'(disp_ready), 64'(1));
        chk("wb_bypass_busy", 64'(rd_busy[0]), 64'(0));
        step();
        idle(); set_lookup(5, 7); #3;
        chk("row5_busy", 64'(busy_vec[5]), 64'(1));
        chk("row5_tag", 64'(rd_tag[1:0]), 64'(1));
        step();

        // Register zero is never allocated
        idle(); set_disp(0, 3, 0); #3;
        chk("zero_ready", 64'(disp_ready), 64'(1));
        step();
        idle(); #3;
        chk("zero_not_busy", 64'(busy_vec[0]), 64'(0));
        step();

        // Speculative dispatch then mispredict
        idle(); set_disp(3, 1, 1); #3; step();
        idle(); set_disp(4, 2, 1); #3; step();
        idle(); set_disp(6, 3, 0); #3; step();
        idle(); #3;
        chk("spec_count_two", 64'(spec_count), 64'(SPEC ? 2 : 0));
        step();
        idle(); br_miss = 1'b1; set_disp(7, 0, 0); #3;
        chk("miss_disp_ready", 64'(disp_ready), 64'(!SPEC));
        step();
        idle(); #3;
        chk("miss_row3", 64'(busy_vec[3]), 64'(!SPEC));
        chk("miss_row4", 64'(busy_vec[4]), 64'(!SPEC));
        chk("miss_row6", 64'(busy_vec[6]), 64'(1));
        chk("miss_count", 64'(spec_count), 64'(0));
        step();

        // Resolve in the same cycle as a speculative dispatch
        idle(); set_disp(9, 0, 1); #3; step();
        idle(); set_disp(10, 1, 1); br_resolved = 1'b1; #3; step();
        idle(); #3;
        chk("res_row9", 64'(busy_vec[9]), 64'(1));
        chk("res_row10", 64'(busy_vec[10]), 64'(1));
        chk("res_count", 64'(spec_count), 64'(0));
        step();
        idle(); br_miss = 1'b1; #3; step();
        idle(); #3;
        chk("res_miss_row9", 64'(busy_vec[9]), 64'(1));
        chk("res_miss_row10", 64'(busy_vec[10]), 64'(1));
        step();

        // Writeback to an idle row is sticky until reset
        idle(); set_wb(0, 12, 1); #3;
        chk("err_before", 64'(wb_err), 64'(0));
        step();
        idle(); #3;
        chk("err_set", 64'(wb_err), 64'(1));
        step();
        idle(); set_wb(1, 5, 1); set_disp(12, 2, 0); #3; step();
        idle(); set_wb(0, 6, 3); set_wb(1, 6, 3); #3; step();
        idle(); set_lookup(6, 12); #3;
        chk("err_sticky", 64'(wb_err), 64'(1));
        chk("dual_wb_row6", 64'(busy_vec[6]), 64'(0));
        step();
        do_reset();

        // Random traffic against the model, with a reset midway
        for (int c = 0; c < 800; c++) begin
            int q[$];
            idle();
            for (int r = 0; r < 8; r++)
                if (m_busy[r]) q.push_back(r);
            if ($urandom_range(0, 1) == 1)
                set_disp(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 1)));
            for (int k = 0; k < NWB; k++) begin
                if ($urandom_range(0, 9) < 4 && q.size() > 0) begin
                    if ($urandom_range(0, 99) < 99) begin
                        int r = q[$urandom_range(0, q.size() - 1)];
                        set_wb(k, r, int'(m_tag[r]));
                    end else begin
                        set_wb(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
                    end
                end
            end
            br_resolved = ($urandom_range(0, 99) < 8);
            br_miss     = ($urandom_range(0, 99) < 5);
            set_lookup(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            #3;
            step();
            if (c == 400) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
